uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
// - Serialises parallel words onto the UART tx line: start bit (0), DBITS data bits LSB first, optional parity, stop bit(s) (1).
// - Timed by the shared baud generator's 16x oversampling sample_tick; the companion of uart_receiver in the UART system.
// - Fed from the TX FIFO through a valid/ready handshake into a one-word holding register, so frames go back-to-back with no idle gap.
// PARAMETERS
// - DBITS      8   data bits per word (5..8)
// - SB_TICK    16  sample ticks in the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2
// - PARITY_ODD 0   parity sense: 0 even, 1 odd; only used when UART_TX_PARITY_EN is defined
// PORTS
// - clk_100MHz    in   1      system clock; all flops on the rising edge
// - reset_n       in   1      asynchronous, active-low reset
// - sample_tick   in   1      1-clk pulse at 16x baud from the baud rate generator
// - tx_valid      in   1      data_in holds a word to send
// - data_in       in   DBITS  word to transmit; stable while tx_valid && !tx_ready
// - tx_ready      out  1      holding register empty; word accepted on the edge where tx_valid && tx_ready
// - tx            out  1      serial line, registered, idles high
// - busy          out  1      state != IDLE
// - tx_done_tick  out  1      1-clk pulse when the last stop tick of a frame completes
// BEHAVIOUR
// - Reset: one clock, asynchronous, active-low. State=IDLE; tx=1; tx_ready=1; busy=0; tx_done_tick=0; hold, shift, tick and bit counters all 0.
// - Holding reg: hold_full set on accept; cleared on the edge that loads the shift reg. tx_ready = !hold_full. tx_valid is ignored while tx_ready=0.
// - Tick counter width is $clog2(max(16,SB_TICK)). It advances only on sample_tick, and sample_tick is ignored in IDLE.
// - IDLE: on a clock with hold_full=1: shift<=hold, hold_full<=0, tick<=0, tx<=0, go START. A word accepted at edge k drives tx low at edge k+1.
// - START: tx=0. On sample_tick with tick==15: go DATA, tick<=0, nbits<=0, tx<=shift[0]. Otherwise tick++.
// - DATA: on sample_tick with tick==15: tick<=0, shift>>=1.
//   - If nbits==DBITS-1: go STOP (tx<=1), or go PARITY when the macro is defined.
//   - Else: nbits++, tx<=next bit.
// - STOP: tx=1. On sample_tick with tick==SB_TICK-1: pulse tx_done_tick for that clock only.
//   - If hold_full=1 on that clock: load shift from hold, tx<=0, go START (the next start bit follows the stop period directly).
//   - Else: go IDLE.
// - Simultaneous accept and stop-end: the accept sets hold_full; the state goes IDLE and the frame starts on the next clock (1-clk gap allowed).
// - Each bit lasts exactly 16 sample_ticks; a frame is (1+DBITS[+1])*16+SB_TICK ticks.
// - Reset asserted mid-frame: tx returns to 1 immediately and both the in-flight word and the held word are discarded.
// CONFIGURATION
// - UART_TX_PARITY_EN defined: PARITY state between DATA and STOP.
//   - tx = ^word ^ PARITY_ODD for 16 ticks; the parity bit is computed from the word captured at load.
// - UART_TX_PARITY_EN undefined: no PARITY state; DATA goes straight to STOP and PARITY_ODD has no effect.
// TESTING
// - Stimulus: sample_tick every 4 clks, DBITS=8, SB_TICK=16, and the frame is sampled at the centre of each 16-tick bit.
// - Reset, then no stimulus -> tx=1, tx_ready=1, busy=0 for 200 clks; sample_tick ignored.
// - Send 0xA5 -> tx=0 one clk after accept; line reads 0,1,0,1,0,0,1,0,1,1 in 64-clk bits; tx_done_tick one pulse; busy falls.
// - Send 0x3C then immediately 0xC3 (tx_valid held) -> second accepted once first loads; second start bit begins on the first frame's final stop tick, no idle.
// - Assert reset_n=0 mid-DATA of 0xFF -> tx=1 asynchronously; after release tx_ready=1, no done pulse, no residual frame.
// - tx_valid with tx_ready=0 and data_in changed -> ignored; the held word is transmitted unchanged.
// - Macro defined, PARITY_ODD=0: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame is 11 bits.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART serialiser (start, DBITS data LSB first, optional parity, stop) fed through a one-word holding register; parity stage enabled by UART_TX_PARITY_EN
module uart_transmitter #(
  parameter int DBITS = 8,
  parameter int SB_TICK = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic             tx_valid,
  input  logic [DBITS-1:0] data_in,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic             tx_done_tick
);
  localparam int TW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW = $clog2(DBITS);
  localparam logic [TW-1:0] BIT_LAST = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DBITS - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t           r_state;
  logic [DBITS-1:0] r_hold;
  logic             r_hold_full;
  logic [DBITS-1:0] r_shift;
  logic [TW-1:0]    r_tick;
  logic [NW-1:0]    r_nbits;
  logic             r_tx;
  logic             r_done;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif
  logic             w_accept;
  assign w_accept     = tx_valid && !r_hold_full;
  assign tx_ready     = !r_hold_full;
  assign tx           = r_tx;
  assign busy         = r_state != IDLE;
  assign tx_done_tick = r_done;
  // Frame sequencer: holding register, shift register, tick/bit counters and the registered line
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_tick      <= '0;
      r_nbits     <= '0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        IDLE: if (r_hold_full) begin
          r_shift     <= r_hold;
          r_hold_full <= 1'b0;
          r_tick      <= '0;
          r_tx        <= 1'b0;
          r_state     <= START;
`ifdef UART_TX_PARITY_EN
          r_par       <= ^r_hold ^ PARITY_ODD;
`endif
        end
        START: if (sample_tick) begin
          if (r_tick == BIT_LAST) begin
            r_state <= DATA;
            r_tick  <= '0;
            r_nbits <= '0;
            r_tx    <= r_shift[0];
          end else r_tick <= r_tick + 1'b1;
        end
        DATA: if (sample_tick) begin
          if (r_tick == BIT_LAST) begin
            r_tick  <= '0;
            r_shift <= r_shift >> 1;
            if (r_nbits == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_par;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_nbits <= r_nbits + 1'b1;
              r_tx    <= r_shift[1];
            end
          end else r_tick <= r_tick + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (sample_tick) begin
          if (r_tick == BIT_LAST) begin
            r_tick  <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
          end else r_tick <= r_tick + 1'b1;
        end
`endif
        STOP: if (sample_tick) begin
          if (r_tick == STOP_LAST) begin
            r_done <= 1'b1;
            r_tick <= '0;
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_tx        <= 1'b0;
              r_state     <= START;
`ifdef UART_TX_PARITY_EN
              r_par       <= ^r_hold ^ PARITY_ODD;
`endif
            end else r_state <= IDLE;
          end else r_tick <= r_tick + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized frame checks of uart_transmitter against a bit-list frame model
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk_100MHz = 1'b0;
  logic reset_n = 1'b0;
  logic sample_tick = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic tx_ready, tx, busy, tx_done_tick;
  int nchecks = 0;
  int nfail = 0;
  int ndone = 0;
  int bad, d0;
  logic [7:0] exp_q[$];
  logic [NB-1:0] got;
  logic dat;
  logic [7:0] w, w2;

  uart_transmitter #(.DBITS(8), .SB_TICK(16), .PARITY_ODD(1'b0)) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .sample_tick(sample_tick),
    .tx_valid(tx_valid),
    .data_in(data_in),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // 16x baud tick: one clock in every four
  initial forever begin
    repeat (3) @(negedge clk_100MHz);
    sample_tick = 1'b1;
    @(negedge clk_100MHz);
    sample_tick = 1'b0;
  end

  always @(negedge clk_100MHz) if (tx_done_tick) ndone <= ndone + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame as the line should carry it, bit k being the k-th bit period
  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    tx_valid = 1'b1;
    data_in = d;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("send_ready", tx_ready, 1);
    if (tx_ready === 1'b1) begin
      @(posedge clk_100MHz);
      exp_q.push_back(d);
      #1;
    end
    tx_valid = 1'b0;
  endtask

  // Waits for a start bit, samples every bit at its centre and compares the frame to the model
  task automatic rx_frame(output logic [NB-1:0] bits, output logic done_at_fall);
    int n;
    logic [7:0] d;
    n = 0;
    bits = '1;
    done_at_fall = 1'b0;
    while (tx !== 1'b0 && n < 5000) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rx_start", tx, 0);
    if (tx === 1'b0) begin
      done_at_fall = tx_done_tick;
      check("rx_expected", exp_q.size() > 0, 1);
      d = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
      for (int k = 0; k < NB; k++) begin
        repeat (k == 0 ? 30 : 64) @(negedge clk_100MHz);
        bits[k] = tx;
      end
      check("rx_frame", bits, frame_of(d));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_100MHz);
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done_tick, 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
    end
    check("idle_200", bad, 0);

    d0 = ndone;
    fork
      begin
        send(8'hA5);
        @(negedge clk_100MHz);
        check("a5_tx_k", tx, 1);
        @(negedge clk_100MHz);
        check("a5_tx_k1", tx, 0);
      end
      rx_frame(got, dat);
    join
`ifndef UART_TX_PARITY_EN
    check("a5_line", got, 10'b1101001010);
`endif
    check("a5_fall_done", dat, 0);
    repeat (40) @(negedge clk_100MHz);
    check("a5_done", ndone - d0, 1);
    check("a5_busy", busy, 0);

    d0 = ndone;
    fork
      begin
        send(8'h3C);
        send(8'hC3);
      end
      begin
        rx_frame(got, dat);
        check("b2b_first_gap", dat, 0);
        rx_frame(got, dat);
        check("b2b_no_gap", dat, 1);
      end
    join
    repeat (40) @(negedge clk_100MHz);
    check("b2b_done", ndone - d0, 2);
    check("b2b_busy", busy, 0);

    fork
      begin
        send(8'h5A);
        send(8'h96);
        tx_valid = 1'b1;
        data_in = 8'hFF;
        bad = 0;
        repeat (20) begin
          @(negedge clk_100MHz);
          if (tx_ready !== 1'b0) bad++;
        end
        check("hold_not_ready", bad, 0);
        tx_valid = 1'b0;
      end
      begin
        rx_frame(got, dat);
        rx_frame(got, dat);
        check("hold_no_gap", dat, 1);
      end
    join
    repeat (40) @(negedge clk_100MHz);
    check("hold_q_empty", exp_q.size(), 0);
    check("hold_busy", busy, 0);

    d0 = ndone;
    send(8'h00);
    repeat (20) @(negedge clk_100MHz);
    check("rst_start_line", tx, 0);
    #2 reset_n = 1'b0;
    #1 check("rst_start_tx", tx, 1);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    exp_q.delete();
    send(8'hFF);
    repeat (150) @(negedge clk_100MHz);
    send(8'h11);
    @(negedge clk_100MHz);
    check("rst_pre_busy", busy, 1);
    check("rst_pre_ready", tx_ready, 0);
    #2 reset_n = 1'b0;
    #1 check("rst_data_tx", tx, 1);
    check("rst_data_ready", tx_ready, 1);
    check("rst_data_busy", busy, 0);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (800) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    check("rst_residual", bad, 0);
    check("rst_no_done", ndone - d0, 0);

    repeat (8) begin
      w = 8'($urandom);
      w2 = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk_100MHz);
      if ($urandom_range(0, 1) == 1) begin
        fork
          begin
            send(w);
            send(w2);
          end
          begin
            rx_frame(got, dat);
            rx_frame(got, dat);
            check("rnd_no_gap", dat, 1);
          end
        join
      end else begin
        fork
          send(w);
          rx_frame(got, dat);
        join
      end
      repeat (40) @(negedge clk_100MHz);
      check("rnd_busy", busy, 0);
    end

`ifdef UART_TX_PARITY_EN
    fork
      send(8'h07);
      rx_frame(got, dat);
    join
    check("par_07", got[9], 1);
    check("par_07_stop", got[10], 1);
    fork
      send(8'h03);
      rx_frame(got, dat);
    join
    check("par_03", got[9], 0);
    check("par_03_stop", got[10], 1);
    repeat (40) @(negedge clk_100MHz);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
